seq_restoring_div: RTL



---
 rtl/seq_restoring_div_pkg.sv | 15 +
 rtl/seq_restoring_div_if.sv | 25 ++
 rtl/seq_restoring_div_sub_borrow.sv | 47 ++++
 rtl/seq_restoring_div.sv | 114 +++++++++++
 4 files changed

// File: rtl/seq_restoring_div_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_restoring_div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_e;

  // Width of the iteration counter for an n-bit divide
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_restoring_div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_restoring_div_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  // Controller side issues requests and consumes results
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side accepts requests and produces results
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_div_sub_borrow.sv
// Combinational W-bit subtractor (sub_borrow): diff = a - b, built as a
// parallel-prefix carry-lookahead adder over a + ~b + 1.
module seq_restoring_div_sub_borrow #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);
  localparam int L = $clog2(W);

  logic [W-1:0]      p0;
  logic [L:0][W-1:0] gg;
  logic [L:0][W-1:0] pp;
  logic [W-1:0]      c;

  // Kogge-Stone prefix over generate/propagate; the +1 carry-in is folded
  // into bit 0's generate so every prefix G[i] is the carry out of bit i.
  always_comb begin
    p0 = a_i ^ ~b_i;
    gg = '0;
    pp = '0;
    gg[0] = a_i & ~b_i;
    gg[0][0] = gg[0][0] | p0[0];
    pp[0] = p0;
    for (int k = 0; k < L; k++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << k)) begin
          gg[k+1][i] = gg[k][i] | (pp[k][i] & gg[k][i-(1<<k)]);
          pp[k+1][i] = pp[k][i] & pp[k][i-(1<<k)];
        end else begin
          gg[k+1][i] = gg[k][i];
          pp[k+1][i] = pp[k][i];
        end
      end
    end
    c = '0;
    c[0] = 1'b1;
    for (int i = 1; i < W; i++) begin
      c[i] = gg[L][i-1];
    end
    diff_o   = p0 ^ c;
    borrow_o = ~gg[L][W-1];
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, single operation in flight.
module seq_restoring_div #(
  parameter int N = 32
) (
  input logic              clk,
  input logic              reset,
  seq_restoring_div_if.slave bus
);
  import seq_restoring_div_pkg::*;

  localparam int                 CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N - 1);

  state_e           state_q;
  logic [N-1:0]     rem_q;
  logic [N-1:0]     q_q;
  logic [N-1:0]     divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [N-1:0]     quot_q;
  logic [N-1:0]     remo_q;
  logic             dbz_q;

  logic [N:0]       rs;
  logic [N:0]       diff;
  logic             borrow;
  logic             diff_msb_unused;
  logic [N-1:0]     rem_d;
  logic [N-1:0]     q_d;

  // The partial remainder shift is N+1 bits so the borrow survives when
  // the remainder MSB is set.
  assign rs = {rem_q, q_q[N-1]};

  seq_restoring_div_sub_borrow #(.W(N + 1)) u_sub (
    .a_i      (rs),
    .b_i      ({1'b0, divisor_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // diff[N] equals the borrow; the dedicated borrow output is used instead.
  assign diff_msb_unused = diff[N];

  // One restoring step: keep the difference unless the subtract borrowed.
  always_comb begin
    rem_d = borrow ? rs[N-1:0] : diff[N-1:0];
    q_d   = {q_q[N-2:0], ~borrow};
  end

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              divisor_q <= bus.divisor;
              rem_q     <= '0;
              q_q       <= bus.dividend;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end else begin
              // Divide by zero finishes immediately with saturated quotient.
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
              quot_q <= '1;
              remo_q <= bus.dividend;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            quot_q  <= q_d;
            remo_q  <= rem_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
